// File: rtl/arb8085_pkg.sv
// Shared definitions for the 8085 memory-port arbiter.
//   state_t : arbiter FSM encoding
//   owner_t : which requester holds (or last held) the memory port
//   DEF_TIMEOUT : default cycles allowed in an access before it is aborted
package arb8085_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/arb_timeout_counter.sv
// Access watchdog for the memory-port arbiter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart count at zero (takes priority over enable)
//   enable     : advance count by one
//   tc         : count has reached TIMEOUT-1
module arb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter_8085.sv
// Shares one memory port between the 8085 CPU controller and a DMA/host loader.
// One owner per access, round-robin on contention, watchdog abort on no mem_ready.
//   cpu_read/cpu_write/cpu_addr/cpu_wdata : CPU request (held while cpu_stall)
//   cpu_rdata/cpu_ack/cpu_stall           : CPU response and freeze
//   dma_req/dma_we/dma_addr/dma_wdata     : DMA request
//   dma_rdata/dma_done                    : DMA response
//   mem_en/mem_we/mem_addr/mem_wdata      : registered memory command
//   mem_rdata/mem_ready                   : memory response
//   bus_err                               : sticky timeout flag, cleared by reset only
module mem_port_arbiter_8085
    import arb8085_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          bus_err
);

    state_t state, state_nxt;
    owner_t last_owner;

    logic cpu_req;
    logic grant_cpu, grant_dma;
    logic acc_done, acc_abort;
    logic tmr_clr, tmr_en, tmr_tc;
    logic [DW-1:0] rd_val;

    // A simultaneous read+write is treated as a write (mem_we follows cpu_write).
    assign cpu_req   = cpu_read | cpu_write;
    assign cpu_stall = cpu_req & ~cpu_ack;
    // Aborted reads return all ones so software sees a recognisable value.
    assign rd_val    = acc_done ? mem_rdata : {DW{1'b1}};

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .tc     (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        acc_done  = 1'b0;
        acc_abort = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port goes to whoever did not have it last.
                if (cpu_req && dma_req) begin
                    grant_cpu = (last_owner == OWN_DMA);
                    grant_dma = (last_owner == OWN_CPU);
                end else begin
                    grant_cpu = cpu_req;
                    grant_dma = dma_req;
                end
                tmr_clr = grant_cpu | grant_dma;
                if (grant_cpu)      state_nxt = CPU_ACC;
                else if (grant_dma) state_nxt = DMA_ACC;
            end
            CPU_ACC, DMA_ACC: begin
                if (mem_ready) begin
                    acc_done  = 1'b1;
                    state_nxt = DONE;
                end else if (tmr_tc) begin
                    acc_abort = 1'b1;
                    state_nxt = DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_done   <= 1'b0;
            bus_err    <= 1'b0;
            last_owner <= OWN_DMA;
        end else begin
            cpu_ack  <= 1'b0;
            dma_done <= 1'b0;
            if (grant_cpu) begin
                mem_en     <= 1'b1;
                mem_we     <= cpu_write;
                mem_addr   <= cpu_addr;
                mem_wdata  <= cpu_wdata;
                last_owner <= OWN_CPU;
            end else if (grant_dma) begin
                mem_en     <= 1'b1;
                mem_we     <= dma_we;
                mem_addr   <= dma_addr;
                mem_wdata  <= dma_wdata;
                last_owner <= OWN_DMA;
            end
            if (acc_done || acc_abort) begin
                mem_en <= 1'b0;
                if (acc_abort)
                    bus_err <= 1'b1;
                if (state == CPU_ACC) begin
                    cpu_ack <= 1'b1;
                    if (!mem_we) cpu_rdata <= rd_val;
                end else begin
                    dma_done <= 1'b1;
                    if (!mem_we) dma_rdata <= rd_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter_8085.sv
module tb_mem_port_arbiter_8085;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_read, cpu_write;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ack, cpu_stall;
    logic       dma_req, dma_we;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic       dma_done;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ready;
    logic       bus_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory model: ready after 'waits' cycles of mem_en, never if 'never_rdy'
    logic [7:0] mem [256];
    int  waits = 0;
    int  wcnt  = 0;
    bit  never_rdy = 1'b0;

    assign mem_ready = mem_en && !never_rdy && (wcnt == waits);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && !mem_ready) wcnt <= wcnt + 1;
        else                      wcnt <= 0;
        if (mem_en && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    always #5 clk = ~clk;

    mem_port_arbiter_8085 dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_done  (dma_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // waits (bounded) for dma_done; returns the cycle it was seen
    task automatic wait_dma_done(input string tag, output int at);
        int k = 0;
        while (!dma_done && k < 40) begin
            tick();
            k++;
        end
        chk(tag, dma_done, 1'b1);
        at = cyc;
    endtask

    initial begin
        int prev, now;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        reset = 1'b1;
        cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_mem_en",    mem_en,    1'b0);
        chk("rst_mem_we",    mem_we,    1'b0);
        chk("rst_mem_addr",  mem_addr,  8'h00);
        chk("rst_cpu_ack",   cpu_ack,   1'b0);
        chk("rst_dma_done",  dma_done,  1'b0);
        chk("rst_bus_err",   bus_err,   1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_dma_rdata", dma_rdata, 8'h00);

        // 1: CPU read, zero-wait
        cpu_read = 1; cpu_addr = 8'h10;
        tick();
        chk("t1_mem_en",    mem_en,    1'b1);
        chk("t1_mem_addr",  mem_addr,  8'h10);
        chk("t1_mem_we",    mem_we,    1'b0);
        chk("t1_stall_acc", cpu_stall, 1'b1);
        tick();
        chk("t1_ack",       cpu_ack,   1'b1);
        chk("t1_rdata",     cpu_rdata, 8'h3C);
        chk("t1_stall_ack", cpu_stall, 1'b0);
        chk("t1_mem_en_lo", mem_en,    1'b0);
        cpu_read = 0;
        tick();
        chk("t1_ack_once",  cpu_ack,   1'b0);
        chk("t1_rdata_hold", cpu_rdata, 8'h3C);

        // 2: tie right after reset, then alternation
        reset = 1; tick(); reset = 0;
        cpu_write = 1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
        dma_req = 1; dma_we = 1; dma_addr = 8'h80; dma_wdata = 8'h22;
        tick();
        chk("t2_g1_addr", mem_addr, 8'h40);
        chk("t2_g1_we",   mem_we,   1'b1);
        tick();
        chk("t2_g1_ack",  cpu_ack,  1'b1);
        tick();
        chk("t2_idle_en", mem_en,   1'b0);
        tick();
        chk("t2_g2_en",   mem_en,   1'b1);
        chk("t2_g2_addr", mem_addr, 8'h80);
        tick();
        chk("t2_g2_done", dma_done, 1'b1);
        chk("t2_g2_noack", cpu_ack, 1'b0);
        tick(); tick();
        chk("t2_g3_addr", mem_addr, 8'h40);
        tick();
        chk("t2_g3_ack",  cpu_ack,  1'b1);
        cpu_write = 0; dma_req = 0;
        tick();
        chk("t2_mem80",   mem[8'h80], 8'h22);

        // 3: DMA write burst, 2-wait memory
        waits = 2;
        dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'hA0;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_dma_done("t3_done", now);
            if (i > 0) chk("t3_spacing", now - prev, 5);
            prev = now;
            if (i == 3) dma_req = 0;
            else begin
                dma_addr  = 8'h21 + 8'(i);
                dma_wdata = 8'hA1 + 8'(i);
            end
            tick();
            chk("t3_done_pulse", dma_done, 1'b0);
        end
        for (int i = 0; i < 4; i++) chk("t3_mem", mem[8'h20 + i], 8'hA0 + i);
        // DMA read back through the port
        dma_req = 1; dma_we = 0; dma_addr = 8'h22;
        wait_dma_done("t3_rd_done", now);
        chk("t3_rd_data", dma_rdata, 8'hA2);
        dma_req = 0;
        tick();

        // 4: timeout on CPU read
        never_rdy = 1; waits = 0;
        cpu_read = 1; cpu_addr = 8'h33;
        for (int i = 0; i < 15; i++) tick();
        chk("t4_still_acc", mem_en,  1'b1);
        chk("t4_no_ack",    cpu_ack, 1'b0);
        chk("t4_no_err",    bus_err, 1'b0);
        tick();
        chk("t4_ack",      cpu_ack,   1'b1);
        chk("t4_rdata",    cpu_rdata, 8'hFF);
        chk("t4_bus_err",  bus_err,   1'b1);
        chk("t4_en_lo",    mem_en,    1'b0);
        cpu_read = 0; never_rdy = 0;
        tick(); tick(); tick();
        chk("t4_err_sticky", bus_err, 1'b1);

        // 5: reset in 2nd cycle of DMA_ACC
        waits = 2;
        dma_req = 1; dma_we = 0; dma_addr = 8'h50;
        tick();
        chk("t5_acc1", mem_en, 1'b1);
        tick();
        reset = 1; dma_req = 0;
        tick();
        chk("t5_en_lo",   mem_en,   1'b0);
        chk("t5_no_done", dma_done, 1'b0);
        chk("t5_err_clr", bus_err,  1'b0);
        reset = 0;
        tick();
        chk("t5_no_done2", dma_done, 1'b0);
        cpu_read = 1; cpu_addr = 8'h60;
        dma_req = 1; dma_addr = 8'h50;
        tick();
        chk("t5_tie_cpu", mem_addr, 8'h60);
        dma_req = 0;
        tick(); tick(); tick();
        chk("t5_cpu_ack", cpu_ack, 1'b1);
        cpu_read = 0;
        tick();

        // 6: read+write together is a write
        waits = 0;
        cpu_read = 1; cpu_write = 1; cpu_addr = 8'h05; cpu_wdata = 8'h77;
        tick();
        chk("t6_we", mem_we, 1'b1);
        chk("t6_wdata", mem_wdata, 8'h77);
        tick();
        chk("t6_ack", cpu_ack, 1'b1);
        chk("t6_mem", mem[8'h05], 8'h77);
        cpu_read = 0; cpu_write = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
